eco_vector_sweeper: RTL and testbench



---
 rtl/eco_pkg.sv | 22 ++
 rtl/eco_misr.sv | 39 +++
 rtl/eco_vector_sweeper.sv | 137 +++++++++++++
 tb/tb_eco_vector_sweeper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/eco_pkg.sv
// Shared constants, sweeper state encoding and vector-count helper for the
// ECO cone signature sweeper.
package eco_pkg;

  localparam int          W_DEF     = 3;
  localparam int          SIG_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_FIN
  } sweep_state_e;

  // Number of (a, b) operand pairs for a two-operand cone of width w.
  function automatic int vec_count(input int w);
    return 1 << (2 * w);
  endfunction

endpackage

// File: rtl/eco_misr.sv
// Multiple-input signature register: Galois-style shift with POLY feedback,
// W-bit data folded into the low bits on each enabled cycle.
module eco_misr
  import eco_pkg::*;
#(
  parameter int               W     = W_DEF,
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [W-1:0]     din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/eco_vector_sweeper.sv
// Exhaustive (a, b) sweep of a W-bit two-operand cone, MISR compaction of
// its y output after LAT cycles, and a golden-signature compare at the end.
module eco_vector_sweeper
  import eco_pkg::*;
#(
  parameter int               W     = W_DEF,
  parameter int               LAT   = 0,
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] exp_sig,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam int                 IDX_W    = 2 * W;
  localparam int                 CNT_W    = 2 * W + 1;
  localparam int                 N_VEC    = vec_count(W);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_VEC - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_VEC - 1);

  sweep_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             start_acc;
  logic             pres_valid;
  logic             absorb;

  // A vector is on a/b during every SWEEP cycle; its y arrives LAT cycles later.
  assign pres_valid = (state_q == ST_SWEEP);

  if (LAT == 0) begin : g_no_pipe
    assign absorb = pres_valid;
  end else begin : g_pipe
    logic [LAT-1:0] pipe_q, pipe_d;

    always_comb pipe_d = LAT'({pipe_q, pres_valid});

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
    end

    assign absorb = pipe_q[LAT-1];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_SWEEP;
          idx_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
        end
      end
      ST_SWEEP, ST_DRAIN: begin
        if (state_q == ST_SWEEP && idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
        if (absorb) cnt_d = cnt_q + CNT_W'(1);
        // The final absorb ends the sweep whether it lands in SWEEP (LAT=0) or DRAIN.
        if (absorb && cnt_q == CNT_LAST) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (state_q == ST_SWEEP && idx_q == IDX_LAST) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN: begin
        pass_d  = (sig == exp_sig);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every control flop, including the index and counters, is reset so an aborted sweep leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  eco_misr #(
    .W    (W),
    .SIG_W(SIG_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .load(start_acc),
    .en  (absorb),
    .din (y_in),
    .sig (sig)
  );

  assign a    = idx_q[IDX_W-1:W];
  assign b    = idx_q[W-1:0];
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_eco_vector_sweeper.sv
// Self-checking bench: LAT=0 and LAT=2 sweepers driven by table-defined cones,
// signatures predicted by a behavioural MISR model over the full vector list.
module tb_eco_vector_sweeper;
  import eco_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start2;
  logic [15:0] exp0, exp2;
  logic [2:0]  a0, b0, a2, b2, y0, y2;
  logic        busy0, busy2, done0, done2, pass0, pass2;
  logic [15:0] sig0, sig2;

  int checks   = 0;
  int failures = 0;

  logic [2:0] tbl[64];
  bit         fault   = 1'b0;
  int         y_delay = 2;
  int         sel     = 0;
  logic [5:0] d1 = '0, d2 = '0;

  logic [2:0]  cur_a, cur_b;
  logic        cur_busy, cur_done, cur_pass;
  logic [15:0] cur_sig;

  always #5 clk = ~clk;

  eco_vector_sweeper #(.W(3), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .exp_sig(exp0),
    .a(a0), .b(b0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .sig(sig0)
  );

  eco_vector_sweeper #(.W(3), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .exp_sig(exp2),
    .a(a2), .b(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .sig(sig2)
  );

  // Combinational cone for dut0, with an optional single-bit fault at a=5, b=2.
  assign y0 = tbl[{a0, b0}] ^ {2'b00, (fault && ({a0, b0} == 6'd42))};

  // Registered cone for dut2: result of the operands from y_delay cycles ago.
  always @(posedge clk) begin
    d1 <= {a2, b2};
    d2 <= d1;
  end
  assign y2 = (y_delay == 2) ? tbl[d2] : tbl[d1];

  always_comb begin
    cur_a    = (sel == 0) ? a0    : a2;
    cur_b    = (sel == 0) ? b0    : b2;
    cur_busy = (sel == 0) ? busy0 : busy2;
    cur_done = (sel == 0) ? done0 : done2;
    cur_pass = (sel == 0) ? pass0 : pass2;
    cur_sig  = (sel == 0) ? sig0  : sig2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else          start2 = v;
  endtask

  task automatic set_exp(input logic [15:0] v);
    if (sel == 0) exp0 = v;
    else          exp2 = v;
  endtask

  // Signature the cone should produce over all 64 pairs in index order.
  function automatic logic [15:0] model_sig(input bit with_fault);
    logic [15:0] s;
    logic [2:0]  y;
    s = 16'hFFFF;
    for (int v = 0; v < 64; v++) begin
      y = tbl[v];
      if (with_fault && v == 5 * 8 + 2) y = y ^ 3'd1;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'd0, y};
    end
    return s;
  endfunction

  // One full sweep on the selected instance, starting from IDLE just after an edge.
  task automatic run_sweep(input string tag, input logic [15:0] exp_in,
                           input logic [15:0] ref_sig, input bit chk_sig,
                           input bit want_pass, input int lat, input bit extra);
    set_exp(exp_in);
    set_start(1'b1);
    step();
    set_start(1'b0);
    check({tag, ":pass_clr"}, 32'(cur_pass), 32'd0);
    for (int i = 0; i < 64; i++) begin
      check({tag, ":ab"}, 32'({cur_a, cur_b}), 32'(i));
      check({tag, ":busy"}, 32'(cur_busy), 32'd1);
      check({tag, ":early_done"}, 32'(cur_done), 32'd0);
      if (extra && (i == 10 || i == 63)) set_start(1'b1);
      step();
      set_start(1'b0);
    end
    for (int j = 0; j < lat; j++) begin
      check({tag, ":drain_ab"}, 32'({cur_a, cur_b}), 32'd63);
      check({tag, ":drain_busy"}, 32'(cur_busy), 32'd1);
      check({tag, ":drain_done"}, 32'(cur_done), 32'd0);
      step();
    end
    check({tag, ":done"}, 32'(cur_done), 32'd1);
    check({tag, ":done_busy"}, 32'(cur_busy), 32'd0);
    if (chk_sig) check({tag, ":sig"}, 32'(cur_sig), 32'(ref_sig));
    if (extra) set_start(1'b1);
    step();
    set_start(1'b0);
    check({tag, ":done_pulse"}, 32'(cur_done), 32'd0);
    check({tag, ":pass"}, 32'(cur_pass), 32'(want_pass));
    check({tag, ":idle_busy"}, 32'(cur_busy), 32'd0);
    step();
    check({tag, ":no_retrig"}, 32'(cur_busy), 32'd0);
    check({tag, ":no_done"}, 32'(cur_done), 32'd0);
    if (chk_sig) check({tag, ":sig_hold"}, 32'(cur_sig), 32'(ref_sig));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] golden;
    int          seen;

    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    exp0   = '0;
    exp2   = '0;
    for (int v = 0; v < 64; v++) tbl[v] = 3'(v >> 3) ^ 3'(v & 7);
    repeat (3) @(posedge clk);
    #1;
    check("rst:ab0", 32'({a0, b0}), 32'd0);
    check("rst:ctl0", 32'({busy0, done0, pass0}), 32'd0);
    check("rst:sig0", 32'(sig0), 32'hFFFF);
    check("rst:ab2", 32'({a2, b2}), 32'd0);
    check("rst:ctl2", 32'({busy2, done2, pass2}), 32'd0);
    check("rst:sig2", 32'(sig2), 32'hFFFF);
    rst = 1'b0;
    step();

    // Golden match with the a^b cone, then a deliberately wrong golden value.
    sel    = 0;
    golden = model_sig(1'b0);
    run_sweep("xor_pass", golden, golden, 1'b1, 1'b1, 0, 1'b0);
    run_sweep("xor_badexp", golden ^ 16'h0001, golden, 1'b1, 1'b0, 0, 1'b0);

    // Single-bit fault on vector (5,2) must change the signature.
    fault = 1'b1;
    run_sweep("fault", golden, model_sig(1'b1), 1'b1, 1'b0, 0, 1'b0);
    check("fault:sig_differs", 32'(sig0 != golden), 32'd1);
    fault = 1'b0;

    // Random cones with stray start pulses during the sweep and in the done cycle.
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 64; v++) tbl[v] = 3'($urandom);
      golden = model_sig(1'b0);
      repeat ($urandom_range(0, 3)) step();
      run_sweep("rand_extra", golden, golden, 1'b1, 1'b1, 0, 1'b1);
    end

    // Two-cycle cone latency, then a cone whose timing is one cycle off.
    sel     = 1;
    y_delay = 2;
    for (int v = 0; v < 64; v++) tbl[v] = 3'($urandom);
    golden = model_sig(1'b0);
    run_sweep("lat2", golden, golden, 1'b1, 1'b1, 2, 1'b0);
    y_delay = 1;
    run_sweep("lat2_vs_lat1", golden, golden, 1'b0, 1'b0, 2, 1'b0);
    check("lat1:sig_differs", 32'(sig2 != golden), 32'd1);
    y_delay = 2;

    // Reset in the middle of a sweep, then a clean full sweep.
    sel = 0;
    for (int v = 0; v < 64; v++) tbl[v] = 3'($urandom);
    golden = model_sig(1'b0);
    run_sweep("pre_rst", golden, golden, 1'b1, 1'b1, 0, 1'b0);
    set_exp(golden);
    set_start(1'b1);
    step();
    set_start(1'b0);
    repeat (20) step();
    check("mid:ab20", 32'({a0, b0}), 32'd20);
    rst = 1'b1;
    #1;
    check("mid_rst:ab", 32'({a0, b0}), 32'd0);
    check("mid_rst:busy", 32'(busy0), 32'd0);
    check("mid_rst:done", 32'(done0), 32'd0);
    check("mid_rst:pass", 32'(pass0), 32'd0);
    check("mid_rst:sig", 32'(sig0), 32'hFFFF);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (70) begin
      step();
      if (done0) seen++;
    end
    check("mid_rst:no_done", 32'(seen), 32'd0);
    run_sweep("post_rst", golden, golden, 1'b1, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
